cska_pipe: RTL and testbench

CSKA_PIPE -- requirements
Module: cska_pipe

---
 rtl/cska_pkg.sv | 14 +
 rtl/cska_block.sv | 32 +++
 rtl/cska_pipe.sv | 148 ++++++++++++++
 tb/tb_cska_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cska_pkg.sv
// Shared constants for the pipelined carry-skip adder: operating modes and
// the stage-count helper used to size the pipeline.
package cska_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  function automatic int cska_latency(input int width, input int block, input int seg_blocks);
    return width / (block * seg_blocks);
  endfunction

endpackage

// File: rtl/cska_block.sv
// One combinational carry-skip block: ripple sum inside, block carry-out
// bypasses the ripple when every bit propagates.
module cska_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] i_a,
  input  logic [BLOCK-1:0] i_b,
  input  logic             i_cin,
  output logic [BLOCK-1:0] o_sum,
  output logic             o_pall,
  output logic             o_cout
);

  logic [BLOCK-1:0] w_p;
  logic [BLOCK-1:0] w_g;
  logic [BLOCK:0]   w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  always_comb begin
    w_c[0] = i_cin;
    for (int i = 0; i < BLOCK; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign o_sum  = w_p ^ w_c[BLOCK-1:0];
  assign o_pall = &w_p;
  assign o_cout = (o_pall & i_cin) | w_c[BLOCK];

endmodule

// File: rtl/cska_pipe.sv
// Pipelined carry-skip add/sub, one BLOCK*SEG_BLOCKS slice per stage, L-cycle latency.
// Valid/ready with a single global advance: every stage holds while the output beat is stalled.
module cska_pipe
  import cska_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int BLOCK      = 4,
  parameter int SEG_BLOCKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int S = BLOCK * SEG_BLOCKS;
  localparam int L = cska_latency(WIDTH, BLOCK, SEG_BLOCKS);

  logic             w_advance;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  // Subtraction is folded in at the input so later stages only ever add.
  assign w_b_eff   = (sub == SUB) ? ~b : b;
  assign w_cin_eff = (sub == SUB) ? 1'b1 : cin;

  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance;

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int LO = k * S;

    logic [S-1:0]          w_a;
    logic [S-1:0]          w_b;
    logic [S-1:0]          w_seg_sum;
    logic                  w_cin;
    logic                  w_vld;
    logic                  w_cout;
    logic [SEG_BLOCKS:0]   w_bc;
    logic [SEG_BLOCKS-1:0] w_pall;
    logic [LO+S-1:0]       w_sum_all;

    logic                  r_vld;
    logic [LO+S-1:0]       r_sum;
    logic                  r_c;

    if (k == 0) begin : g_in
      assign w_a       = a[S-1:0];
      assign w_b       = w_b_eff[S-1:0];
      assign w_cin     = w_cin_eff;
      assign w_vld     = in_valid;
      assign w_sum_all = w_seg_sum;
    end else begin : g_in
      assign w_a       = g_stage[k-1].g_rem.r_a[S-1:0];
      assign w_b       = g_stage[k-1].g_rem.r_b[S-1:0];
      assign w_cin     = g_stage[k-1].r_c;
      assign w_vld     = g_stage[k-1].r_vld;
      assign w_sum_all = {w_seg_sum, g_stage[k-1].r_sum};
    end

    assign w_bc[0] = w_cin;

    for (genvar j = 0; j < SEG_BLOCKS; j++) begin : g_blk
      cska_block #(
        .BLOCK (BLOCK)
      ) u_blk (
        .i_a    (w_a[j*BLOCK +: BLOCK]),
        .i_b    (w_b[j*BLOCK +: BLOCK]),
        .i_cin  (w_bc[j]),
        .o_sum  (w_seg_sum[j*BLOCK +: BLOCK]),
        .o_pall (w_pall[j]),
        .o_cout (w_bc[j+1])
      );
    end

    // Second skip level: a fully propagating stage passes its carry-in straight on.
    assign w_cout = ((&w_pall) & w_cin) | w_bc[SEG_BLOCKS];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_sum <= '0;
        r_c   <= 1'b0;
      end else if (w_advance) begin
        r_vld <= w_vld;
        r_sum <= w_sum_all;
        r_c   <= w_cout;
      end
    end

    // Operand bits still to be consumed by later stages ride along with the beat.
    if (k < L - 1) begin : g_rem
      localparam int RW = WIDTH - (k + 1) * S;

      logic [RW-1:0] w_a_rem;
      logic [RW-1:0] w_b_rem;
      logic [RW-1:0] r_a;
      logic [RW-1:0] r_b;

      if (k == 0) begin : g_src
        assign w_a_rem = a[WIDTH-1:S];
        assign w_b_rem = w_b_eff[WIDTH-1:S];
      end else begin : g_src
        assign w_a_rem = g_stage[k-1].g_rem.r_a[RW+S-1:S];
        assign w_b_rem = g_stage[k-1].g_rem.r_b[RW+S-1:S];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_advance) begin
          r_a <= w_a_rem;
          r_b <= w_b_rem;
        end
      end
    end

    if (k == L - 1) begin : g_last
      logic r_ovf;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_advance) begin
          r_ovf <= w_a[S-1] ^ w_b[S-1] ^ w_seg_sum[S-1] ^ w_cout;
        end
      end
    end
  end

  assign out_valid = g_stage[L-1].r_vld;
  assign sum       = g_stage[L-1].r_sum;
  assign cout      = g_stage[L-1].r_c;
  assign ovf       = g_stage[L-1].g_last.r_ovf;
  assign zero      = ~|sum;

endmodule

// File: tb/tb_cska_pipe.sv
// Randomized bench for cska_pipe with a plain-arithmetic reference model and a
// per-cycle scoreboard on the output handshake.
module tb_cska_pipe;

  localparam int WIDTH      = 32;
  localparam int BLOCK      = 4;
  localparam int SEG_BLOCKS = 2;
  localparam int L          = WIDTH / (BLOCK * SEG_BLOCKS);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             cin       = 1'b0;
  logic             sub       = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_out    = 0;

  always #5 clk = ~clk;

  cska_pipe #(
    .WIDTH      (WIDTH),
    .BLOCK      (BLOCK),
    .SEG_BLOCKS (SEG_BLOCKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // Reference: unsigned sum for result/carry, true signed value for overflow.
  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci, input logic s);
    res_t           r;
    logic [WIDTH:0] u;
    longint         sx, sy, sr, smax, smin;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    smax = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin = -(longint'(1) <<< (WIDTH - 1));
    if (s) begin
      u  = {1'b0, x} + {1'b0, ~y} + 1;
      sr = sx - sy;
    end else begin
      u  = {1'b0, x} + {1'b0, y} + (ci ? 1 : 0);
      sr = sx + sy + (ci ? 1 : 0);
    end
    r.sum  = u[WIDTH-1:0];
    r.cout = u[WIDTH];
    r.zero = (r.sum == '0);
    r.ovf  = (sr > smax) || (sr < smin);
    return r;
  endfunction

  task automatic check_w(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, wanted %h", name, act, req);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b, wanted %b", name, act, req);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic drive(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic ci, input logic s);
    a        = x;
    b        = y;
    cin      = ci;
    sub      = s;
    in_valid = 1'b1;
  endtask

  task automatic drive_rnd();
    drive(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Scoreboard: output handshake pops the oldest expected beat; input handshake pushes.
  always @(negedge clk) begin
    res_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL spurious_out: out_valid=1 sum=%h with no beat outstanding", sum);
        end else begin
          e = exp_q.pop_front();
          check_w("sb_sum", sum, e.sum);
          check_b("sb_cout", cout, e.cout);
          check_b("sb_ovf", ovf, e.ovf);
          check_b("sb_zero", zero, e.zero);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic directed(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic ci, input logic s, input logic [WIDTH-1:0] esum,
                          input logic ecout, input logic eovf, input logic ezero);
    int cyc;
    @(posedge clk); #1;
    drive(x, y, ci, s);
    @(negedge clk);
    check_b({name, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    @(negedge clk);
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_w({name, "_latency"}, cyc, L);
    check_w({name, "_sum"}, sum, esum);
    check_b({name, "_cout"}, cout, ecout);
    check_b({name, "_ovf"}, ovf, eovf);
    check_b({name, "_zero"}, zero, ezero);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t r;
    int   cnt;
    int   n0;

    // Reset state
    #12;
    check_b("rst_out_valid", out_valid, 1'b0);
    check_w("rst_sum", sum, '0);
    check_b("rst_cout", cout, 1'b0);
    check_b("rst_ovf", ovf, 1'b0);
    check_b("rst_zero", zero, 1'b1);
    #9 rst_n = 1'b1;
    #1 check_b("rel_in_ready", in_ready, 1'b1);

    // Pin the reference model with hand-computed results
    r = model(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    check_w("model_skip_sum", r.sum, 32'h0);
    check_b("model_skip_cout", r.cout, 1'b1);
    check_b("model_skip_ovf", r.ovf, 1'b0);
    r = model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    check_w("model_ovf_sum", r.sum, 32'h8000_0000);
    check_b("model_ovf_ovf", r.ovf, 1'b1);
    r = model(32'h5, 32'h7, 1'b0, 1'b1);
    check_w("model_sub_neg_sum", r.sum, 32'hFFFF_FFFE);
    check_b("model_sub_neg_cout", r.cout, 1'b0);
    r = model(32'h7, 32'h5, 1'b1, 1'b1);
    check_w("model_sub_pos_sum", r.sum, 32'h2);
    check_b("model_sub_pos_cout", r.cout, 1'b1);

    // Directed corner beats through the DUT
    directed("full_skip", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    directed("signed_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("sub_borrow", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed("sub_noborrow", 32'h7, 32'h5, 1'b1, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0);

    // 100 back-to-back beats: all must exit one per cycle by L cycles after the last accept
    out_ready = 1'b1;
    @(posedge clk); #1;
    n0 = n_out;
    for (int i = 0; i < 100; i++) begin
      drive_rnd();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (L - 1) @(posedge clk);
    @(negedge clk); #1;
    check_w("b2b_out_count", n_out - n0, 100);
    check_w("b2b_q_empty", exp_q.size(), 0);

    // Random valid / ready on both sides
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) drive_rnd();
      else in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1 check_w("rnd_drain_q_empty", exp_q.size(), 0);

    // Fill with output blocked, hold 5 cycles, then release with traffic still arriving
    @(posedge clk); #1;
    out_ready = 1'b0;
    cnt = 0;
    drive_rnd();
    while (in_ready && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
      drive_rnd();
    end
    check_w("stall_fill_count", cnt, L);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_b("stall_in_ready", in_ready, 1'b0);
      check_b("stall_out_valid", out_valid, 1'b1);
      if (exp_q.size() == 0) begin
        check_w("stall_q_depth", exp_q.size(), L);
      end else begin
        check_w("stall_sum_frozen", sum, exp_q[0].sum);
        check_b("stall_cout_frozen", cout, exp_q[0].cout);
        check_b("stall_ovf_frozen", ovf, exp_q[0].ovf);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_rnd();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1 check_w("stall_drain_q_empty", exp_q.size(), 0);

    // Reset with 3 beats in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rnd();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_b("rst_pre_out_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_b("rst_async_out_valid", out_valid, 1'b0);
    check_w("rst_async_sum", sum, '0);
    check_b("rst_async_zero", zero, 1'b1);
    check_b("rst_async_cout", cout, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    #1 check_b("rst_rel_in_ready", in_ready, 1'b1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check_w("rst_stale_beats", cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
